alu: RTL and testbench



---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_if.sv | 28 ++
 rtl/alu_addsub.sv | 27 ++
 rtl/alu.sv | 75 +++++++
 tb/tb_alu.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Purpose: shared operation codes and types for the registered N-bit ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_AND  = 3'b000;
    localparam alu_op_t ALU_OR   = 3'b001;
    localparam alu_op_t ALU_ADD  = 3'b010;
    localparam alu_op_t ALU_XOR  = 3'b011;
    localparam alu_op_t ALU_ANDN = 3'b100;
    localparam alu_op_t ALU_ORN  = 3'b101;
    localparam alu_op_t ALU_SUB  = 3'b110;
    localparam alu_op_t ALU_SLT  = 3'b111;

endpackage

// File: rtl/alu_if.sv
// Purpose: operand/control inputs and registered result/flag outputs of the ALU.
// Latency: n/a (wiring only).
// Backpressure: none; the ALU accepts a new operation every cycle.
// Ports: SrcA, SrcB, ALUControl (master -> ALU); ALUResult, Zero, Overflow, CarryOut (ALU -> master).
interface alu_if #(
    parameter int N_bit = 32
);
    import alu_pkg::*;

    logic [N_bit-1:0] SrcA;
    logic [N_bit-1:0] SrcB;
    alu_op_t          ALUControl;
    logic [N_bit-1:0] ALUResult;
    logic             Zero;
    logic             Overflow;
    logic             CarryOut;

    modport master (
        output SrcA, SrcB, ALUControl,
        input  ALUResult, Zero, Overflow, CarryOut
    );

    modport slave (
        input  SrcA, SrcB, ALUControl,
        output ALUResult, Zero, Overflow, CarryOut
    );

endinterface

// File: rtl/alu_addsub.sv
// Purpose: shared N-bit adder/subtractor (a + b, or a + ~b + 1 when sub is set).
// Latency: combinational.
// Backpressure: none.
// Ports: a, b operands; sub selects subtraction; sum, cout (bit-N carry), ovf (signed overflow).
module alu_addsub #(
    parameter int N_bit = 32
) (
    input  logic [N_bit-1:0] a,
    input  logic [N_bit-1:0] b,
    input  logic             sub,
    output logic [N_bit-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [N_bit-1:0] b_eff;
    logic [N_bit:0]   full;

    assign b_eff       = sub ? ~b : b;
    assign full        = {1'b0, a} + {1'b0, b_eff} + {{N_bit{1'b0}}, sub};
    assign sum         = full[N_bit-1:0];
    assign cout        = full[N_bit];
    // Comparing against the effective B operand covers both cases:
    // same-sign add, and different-sign subtract whose result flips away from A.
    assign ovf         = (a[N_bit-1] == b_eff[N_bit-1]) && (sum[N_bit-1] != a[N_bit-1]);

endmodule

// File: rtl/alu.sv
// Purpose: N-bit ALU with eight operations, registered result and Zero/Overflow/CarryOut flags.
// Latency: 1 cycle (inputs sampled on rising clk, outputs valid after that edge).
// Backpressure: none; one operation per cycle, outputs hold until the next edge.
// Ports: clk, reset (async active-high, forces ALUResult=0, Zero=1, flags=0); bus (alu_if slave).
module alu
    import alu_pkg::*;
#(
    parameter int N_bit = 32
) (
    input  logic clk,
    input  logic reset,
    alu_if.slave bus
);

    alu_op_t          op;
    logic [N_bit-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             sub;
    logic             arith;
    logic [N_bit-1:0] result_d;
    logic             zero_d;
    logic             ovf_d;
    logic             cout_d;

    assign op = bus.ALUControl;

    // SLT rides on the subtractor, so it needs the inverted B and carry-in of 1 too.
    assign sub   = (op == ALU_SUB) || (op == ALU_SLT);
    assign arith = (op == ALU_ADD) || (op == ALU_SUB);

    alu_addsub #(.N_bit(N_bit)) u_addsub (
        .a    (bus.SrcA),
        .b    (bus.SrcB),
        .sub  (sub),
        .sum  (sum),
        .cout (cout),
        .ovf  (ovf)
    );

    always_comb begin
        result_d = '0;
        case (op)
            ALU_AND:  result_d = bus.SrcA & bus.SrcB;
            ALU_OR:   result_d = bus.SrcA | bus.SrcB;
            ALU_ADD:  result_d = sum;
            ALU_XOR:  result_d = bus.SrcA ^ bus.SrcB;
            ALU_ANDN: result_d = bus.SrcA & ~bus.SrcB;
            ALU_ORN:  result_d = bus.SrcA | ~bus.SrcB;
            ALU_SUB:  result_d = sum;
            // Sign of the difference corrected by overflow gives a signed compare
            // that holds across the full two's complement range.
            ALU_SLT:  result_d = {{(N_bit-1){1'b0}}, sum[N_bit-1] ^ ovf};
        endcase
    end

    assign zero_d = (result_d == '0);
    assign ovf_d  = arith & ovf;
    assign cout_d = arith & cout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.ALUResult <= '0;
            bus.Zero      <= 1'b1;
            bus.Overflow  <= 1'b0;
            bus.CarryOut  <= 1'b0;
        end else begin
            bus.ALUResult <= result_d;
            bus.Zero      <= zero_d;
            bus.Overflow  <= ovf_d;
            bus.CarryOut  <= cout_d;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Purpose: self-checking bench for alu at N_bit = 4, scoreboard of expected results.
// Latency: checks each result one clock after its inputs are applied.
// Backpressure: n/a.
module tb_alu;
    import alu_pkg::*;

    localparam int N = 4;

    typedef struct packed {
        logic [N-1:0] res;
        logic         z;
        logic         v;
        logic         c;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    alu_if #(.N_bit(N)) bus ();

    alu #(.N_bit(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   total    = 0;

    // Independent reference: integer arithmetic on the unsigned and signed views.
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input alu_op_t op);
        exp_t e;
        int   ua;
        int   ub;
        int   sa;
        int   sbv;
        int   t;
        int   st;
        ua  = int'(a);
        ub  = int'(b);
        sa  = $signed(a);
        sbv = $signed(b);
        e   = '0;
        case (op)
            ALU_AND:  e.res = a & b;
            ALU_OR:   e.res = a | b;
            ALU_XOR:  e.res = a ^ b;
            ALU_ANDN: e.res = a & ~b;
            ALU_ORN:  e.res = a | ~b;
            ALU_ADD: begin
                t     = ua + ub;
                st    = sa + sbv;
                e.res = t[N-1:0];
                e.c   = (t >= (1 << N));
                e.v   = (st < -(1 << (N-1))) || (st > (1 << (N-1)) - 1);
            end
            ALU_SUB: begin
                t     = ua - ub;
                st    = sa - sbv;
                e.res = t[N-1:0];
                e.c   = (ua >= ub);
                e.v   = (st < -(1 << (N-1))) || (st > (1 << (N-1)) - 1);
            end
            ALU_SLT:  e.res = (sa < sbv) ? N'(1) : N'(0);
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
        total++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: got %b want %b", tag, obs, expv);
    endtask

    task automatic chk_out(input string tag, input exp_t e);
        chk({tag, ".res"}, bus.ALUResult, e.res);
        chk({tag, ".zero"}, N'(bus.Zero), N'(e.z));
        chk({tag, ".ovf"}, N'(bus.Overflow), N'(e.v));
        chk({tag, ".cout"}, N'(bus.CarryOut), N'(e.c));
    endtask

    task automatic chk_reset(input string tag);
        exp_t e;
        e     = '0;
        e.z   = 1'b1;
        chk_out(tag, e);
    endtask

    // Drive one operation, check it one edge later, then disturb the inputs
    // mid-cycle and confirm the registered outputs do not move.
    task automatic apply(input logic [N-1:0] a, input logic [N-1:0] b, input alu_op_t op, input string tag);
        exp_t e;
        @(negedge clk);
        bus.SrcA       = a;
        bus.SrcB       = b;
        bus.ALUControl = op;
        exp_q.push_back(model(a, b, op));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            total++;
            $error("FAIL %s: scoreboard empty, got %b want an entry", tag, bus.ALUResult);
        end else begin
            e = exp_q.pop_front();
            chk_out(tag, e);
            #2;
            bus.SrcA       = N'($urandom);
            bus.SrcB       = N'($urandom);
            bus.ALUControl = alu_op_t'($urandom_range(0, 7));
            #1;
            chk_out({tag, ".hold"}, e);
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.SrcA       = '0;
        bus.SrcB       = '0;
        bus.ALUControl = ALU_AND;
        #2;
        chk_reset("reset_init");
        @(posedge clk);
        #1;
        chk_reset("reset_held");
        @(negedge clk);
        reset = 1'b0;

        apply(4'b1010, 4'b0101, ALU_OR, "or_after_reset");

        // Asynchronous reset in the middle of a cycle clears outputs at once.
        #1;
        reset = 1'b1;
        #1;
        chk_reset("reset_async");
        @(negedge clk);
        reset = 1'b0;

        apply(4'b1010, 4'b0101, ALU_AND,  "and_zero");
        apply(4'b1010, 4'b0101, ALU_OR,   "or");
        apply(4'b1010, 4'b1000, ALU_XOR,  "xor");
        apply(4'b1010, 4'b1000, ALU_ANDN, "andn");
        apply(4'b0011, 4'b0011, ALU_ORN,  "orn_all1");
        apply(4'b0010, 4'b0101, ALU_ORN,  "orn");
        apply(4'b0010, 4'b0101, ALU_ADD,  "add");
        apply(4'b0111, 4'b0001, ALU_ADD,  "add_ovf");
        apply(4'b1111, 4'b0001, ALU_ADD,  "add_carry");
        apply(4'b0010, 4'b0101, ALU_SUB,  "sub_borrow");
        apply(4'b0010, 4'b0001, ALU_SUB,  "sub");
        apply(4'b0010, 4'b0010, ALU_SUB,  "sub_zero");
        apply(4'b1000, 4'b0001, ALU_SUB,  "sub_ovf");
        apply(4'b0010, 4'b0101, ALU_SLT,  "slt_lt");
        apply(4'b0101, 4'b0010, ALU_SLT,  "slt_ge");
        apply(4'b1000, 4'b0111, ALU_SLT,  "slt_ovf");
        apply(4'b0111, 4'b1000, ALU_SLT,  "slt_pos_neg");

        // Reset between drive and edge: the in-flight ADD must never surface.
        @(negedge clk);
        bus.SrcA       = 4'b0111;
        bus.SrcB       = 4'b0001;
        bus.ALUControl = ALU_ADD;
        #2;
        reset = 1'b1;
        #1;
        chk_reset("reset_midstream");
        @(posedge clk);
        #1;
        chk_reset("reset_midstream_held");
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset("reset_released");
        apply(4'b0110, 4'b0110, ALU_XOR, "xor_after_reset");

        // Back-to-back operations across all eight codes.
        for (int i = 0; i < 32; i++) begin
            apply(N'($urandom), N'($urandom), alu_op_t'(i % 8), "pipe");
        end

        total++;
        assert (exp_q.size() == 0) pass_cnt++;
        else $error("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
